// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the dual-port RAM access controller.
package ram_ctrl_pkg;

    localparam int unsigned ADDR_WIDTH = 5;
    localparam int unsigned DATA_WIDTH = 8;

    // Index of a write requester (0 = w0, 1 = w1).
    typedef logic req_idx_t;

    localparam req_idx_t RST_LAST = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: grants are one-hot or zero, the pointer tracks the
// most recent winner so that the other requester wins the next tie.
module rr_arb2
    import ram_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       gnt_en,
    output logic [1:0] gnt,
    output req_idx_t   last
);

    logic [1:0] w_gnt;
    req_idx_t   r_last;

    always_comb begin
        w_gnt = '0;
        if (gnt_en) begin
            case (req)
                2'b01:   w_gnt = 2'b01;
                2'b10:   w_gnt = 2'b10;
                2'b11:   w_gnt = (r_last == 1'b1) ? 2'b01 : 2'b10;
                default: w_gnt = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= RST_LAST;
        end else if (|w_gnt) begin
            r_last <= w_gnt[1];
        end
    end

    assign gnt  = w_gnt;
    assign last = r_last;

endmodule

// File: rtl/ram_2port_ctrl.sv
// Access controller for a simple dual-port RAM: round-robin arbitration of two
// writers, pipelined synchronous reads, and a stall on same-address write/read.
module ram_2port_ctrl #(
    parameter int unsigned ADDR_WIDTH = ram_ctrl_pkg::ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = ram_ctrl_pkg::DATA_WIDTH,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  w0_req,
    input  logic [ADDR_WIDTH-1:0] w0_addr,
    input  logic [DATA_WIDTH-1:0] w0_data,
    output logic                  w0_gnt,
    input  logic                  w1_req,
    input  logic [ADDR_WIDTH-1:0] w1_addr,
    input  logic [DATA_WIDTH-1:0] w1_data,
    output logic                  w1_gnt,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr_in,
    output logic                  rd_ack,
    output logic                  rd_vld,
    output logic [DATA_WIDTH-1:0] rd_dout,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic                  ram_rst
);

    import ram_ctrl_pkg::*;

    logic [1:0]            w_req;
    logic [1:0]            w_gnt;
    req_idx_t              w_last_unused;
    req_idx_t              w_wr_idx;
    logic                  w_wr_go;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic                  w_hazard;
    logic                  w_rd_ack;

    logic                  r_wr_en;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic [RD_LATENCY:0]   r_vld_pipe;
    logic                  r_rd_vld;
    logic [DATA_WIDTH-1:0] r_rd_dout;

    assign w_req = {w1_req, w0_req};

    rr_arb2 u_arb (
        .clk    (sys_clk),
        .rst_n  (sys_rst_n),
        .req    (w_req),
        .gnt_en (1'b1),
        .gnt    (w_gnt),
        .last   (w_last_unused)
    );

    assign w_wr_go   = |w_gnt;
    assign w_wr_idx  = w_gnt[1];
    assign w_wr_addr = w_wr_idx ? w1_addr : w0_addr;
    assign w_wr_data = w_wr_idx ? w1_data : w0_data;

    // A read of the address being written this cycle would hit the RAM on the
    // same edge as the write; hold it off so it observes the new data.
    assign w_hazard  = w_wr_go && (w_wr_addr == rd_addr_in);
    assign w_rd_ack  = rd_req && !w_hazard;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= w_wr_go;
            if (w_wr_go) begin
                r_wr_addr <= w_wr_addr;
                r_wr_data <= w_wr_data;
            end
        end
    end

    // Stage RD_LATENCY lines up with the RAM output for the address issued
    // RD_LATENCY+1 edges earlier.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_rd_addr  <= '0;
            r_vld_pipe <= '0;
            r_rd_vld   <= 1'b0;
            r_rd_dout  <= '0;
        end else begin
            if (w_rd_ack) begin
                r_rd_addr <= rd_addr_in;
            end
            r_vld_pipe <= {r_vld_pipe[RD_LATENCY-1:0], w_rd_ack};
            r_rd_vld   <= r_vld_pipe[RD_LATENCY];
            if (r_vld_pipe[RD_LATENCY]) begin
                r_rd_dout <= ram_rd_data;
            end
        end
    end

    assign w0_gnt      = w_gnt[0];
    assign w1_gnt      = w_gnt[1];
    assign rd_ack      = w_rd_ack;
    assign rd_vld      = r_rd_vld;
    assign rd_dout     = r_rd_dout;
    assign ram_wr_en   = r_wr_en;
    assign ram_wr_addr = r_wr_addr;
    assign ram_wr_data = r_wr_data;
    assign ram_rd_addr = r_rd_addr;
    assign ram_rst     = ~sys_rst_n;

endmodule
